load_store_unit: RTL and testbench

- Memory-access stage between the CPU datapath and the 64-byte, byte-addressed, big-endian, 24-bit-word data memory.
- The data memory reads combinationally and writes synchronously.
- Accepts one request per handshake for word or byte loads/stores:
  - performs bounds checking;
  - sign/zero-extends byte loads;
  - implements byte stores as read-modify-write of a 3-byte window.
- Drives the data memory's Address/WriteData/MemWrite/MemRead and consumes its ReadData.

---
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store stage: bounds-checked word/byte access to a 24-bit big-endian
// data memory, with byte stores done as read-modify-write of a 3-byte window.
module load_store_unit #(
    parameter int MEM_BYTES = 64
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req,
    input  logic [2:0]  Op,
    input  logic [23:0] Addr,
    input  logic [23:0] StoreData,
    output logic        Busy,
    output logic        Done,
    output logic        Fault,
    output logic [23:0] LoadData,
    output logic [23:0] MemAddress,
    output logic [23:0] MemWriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [23:0] MemReadData
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_SW  = 3'b011;
    localparam logic [2:0] OP_SB  = 3'b100;

    localparam logic [23:0] WORD_MAX = 24'(MEM_BYTES - 3);
    localparam logic [23:0] BYTE_MAX = 24'(MEM_BYTES - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [23:0] addr_q, addr_d;
    logic [23:0] data_q, data_d;
    logic [23:0] merged_q, merged_d;
    logic [23:0] load_q, load_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;

    logic        in_word, in_byte, in_ok;
    logic        q_word;
    logic [23:0] base;
    logic [1:0]  k;
    logic [7:0]  sel_byte;
    logic [23:0] merged;

    // Request validity, window base and byte lane selection
    always_comb begin
        in_word = (Op == OP_LW) || (Op == OP_SW);
        in_byte = (Op == OP_LB) || (Op == OP_LBU) || (Op == OP_SB);
        in_ok   = (in_word && (Addr <= WORD_MAX))
               || (in_byte && (Addr <= BYTE_MAX));
        q_word  = (op_q == OP_LW) || (op_q == OP_SW);
        base    = (q_word || (addr_q <= WORD_MAX)) ? addr_q : WORD_MAX;
        // Byte ops near the top of memory slide the window down
        if (q_word || (addr_q <= WORD_MAX))
            k = 2'd0;
        else if (addr_q == BYTE_MAX)
            k = 2'd2;
        else
            k = 2'd1;
        sel_byte = MemReadData[7:0];
        merged   = {MemReadData[23:8], data_q[7:0]};
        unique case (k)
            2'd0: begin
                sel_byte = MemReadData[23:16];
                merged   = {data_q[7:0], MemReadData[15:0]};
            end
            2'd1: begin
                sel_byte = MemReadData[15:8];
                merged   = {MemReadData[23:16], data_q[7:0],
                            MemReadData[7:0]};
            end
            default: begin
                sel_byte = MemReadData[7:0];
                merged   = {MemReadData[23:8], data_q[7:0]};
            end
        endcase
    end

    // Next-state logic for the access FSM and completion flags
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        data_d   = data_q;
        merged_d = merged_q;
        load_d   = load_q;
        done_d   = 1'b0;
        fault_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (Req) begin
                    op_d   = Op;
                    addr_d = Addr;
                    data_d = StoreData;
                    if (in_ok) begin
                        state_d = ST_ACCESS;
                    end else begin
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                unique case (op_q)
                    OP_LW:  load_d = MemReadData;
                    OP_LB:  load_d = {{16{sel_byte[7]}}, sel_byte};
                    OP_LBU: load_d = {16'h0000, sel_byte};
                    OP_SB: begin
                        merged_d = merged;
                        state_d  = ST_WRITE;
                        done_d   = 1'b0;
                    end
                    default: ;
                endcase
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory-side drive; writes are suppressed by a coincident reset
    always_comb begin
        MemAddress   = 24'h0;
        MemWriteData = 24'h0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        unique case (state_q)
            ST_ACCESS: begin
                MemAddress = base;
                if (op_q == OP_SW) begin
                    MemWrite     = ~Reset;
                    MemWriteData = data_q;
                end else begin
                    MemRead = 1'b1;
                end
            end
            ST_WRITE: begin
                MemAddress   = base;
                MemWriteData = merged_q;
                MemWrite     = ~Reset;
            end
            default: ;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'b000;
            addr_q   <= 24'h0;
            data_q   <= 24'h0;
            merged_q <= 24'h0;
            load_q   <= 24'h0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            merged_q <= merged_d;
            load_q   <= load_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
        end
    end

    assign Busy     = (state_q != ST_IDLE);
    assign Done     = done_q;
    assign Fault    = fault_q;
    assign LoadData = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory model, per-cycle expected
// outputs predicted from the access rules, directed cases plus random ops.
module tb_load_store_unit;

    localparam int MEM  = 64;
    localparam int MAXC = 8192;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Req = 1'b0;
    logic [2:0]  Op = 3'b000;
    logic [23:0] Addr = 24'h0;
    logic [23:0] StoreData = 24'h0;
    logic        Busy, Done, Fault, MemWrite, MemRead;
    logic [23:0] LoadData, MemAddress, MemWriteData;
    logic [23:0] rd;

    logic [7:0] mem  [0:MEM-1];
    logic [7:0] refm [0:MEM-1];

    bit        exp_busy  [MAXC];
    bit        exp_done  [MAXC];
    bit        exp_fault [MAXC];
    bit        exp_isld  [MAXC];
    bit        exp_clr   [MAXC];
    bit        exp_mr    [MAXC];
    bit        exp_mw    [MAXC];
    bit [23:0] exp_ld    [MAXC];
    bit [23:0] exp_ma    [MAXC];
    bit [23:0] exp_mwd   [MAXC];

    int          cyc = 0;
    int          free_at = 0;
    int          errors = 0;
    int          checks = 0;
    logic [23:0] held = 24'h0;

    load_store_unit #(.MEM_BYTES(MEM)) dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .Op(Op),
        .Addr(Addr), .StoreData(StoreData), .Busy(Busy),
        .Done(Done), .Fault(Fault), .LoadData(LoadData),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(rd)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    always_comb begin
        rd = 24'h0;
        if (MemAddress < 24'd62)
            rd = {mem[MemAddress[5:0]], mem[MemAddress[5:0] + 6'd1],
                  mem[MemAddress[5:0] + 6'd2]};
    end

    always @(posedge Clock) begin
        if (MemWrite && MemAddress < 24'd62) begin
            mem[MemAddress[5:0]]        <= MemWriteData[23:16];
            mem[MemAddress[5:0] + 6'd1] <= MemWriteData[15:8];
            mem[MemAddress[5:0] + 6'd2] <= MemWriteData[7:0];
        end
    end

    task automatic chk(input string nm, input logic [23:0] act,
                       input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] win(input int b);
        return {refm[b], refm[b+1], refm[b+2]};
    endfunction

    // Per-cycle comparison against the predicted timeline
    always @(negedge Clock) begin
        if (cyc >= 1 && cyc < MAXC) begin
            if (exp_clr[cyc])
                held = 24'h0;
            else if (exp_done[cyc] && exp_isld[cyc])
                held = exp_ld[cyc];
            chk1("busy", Busy, exp_busy[cyc]);
            chk1("done", Done, exp_done[cyc]);
            chk1("fault", Fault, exp_fault[cyc]);
            chk("loaddata", LoadData, held);
            chk1("memread", MemRead, exp_mr[cyc]);
            chk1("memwrite", MemWrite, exp_mw[cyc]);
            chk("memaddr", MemAddress, exp_ma[cyc]);
            chk("memwdata", MemWriteData, exp_mwd[cyc]);
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Predict the whole transaction accepted at edge n
    task automatic model(input logic [2:0] op, input logic [23:0] addr,
                         input logic [23:0] data, input bit abort,
                         input int n, output int d);
        int a, b, lat;
        bit ok, word;
        logic [7:0] old, by;
        logic [23:0] mw;
        a    = int'(addr);
        word = (op == 3'd0) || (op == 3'd3);
        if (word)
            ok = (a <= MEM - 3);
        else if (op == 3'd1 || op == 3'd2 || op == 3'd4)
            ok = (a <= MEM - 1);
        else
            ok = 1'b0;
        b = (word || a <= MEM - 3) ? a : MEM - 3;
        if (!ok) begin
            lat = 0;
            exp_fault[n] = 1'b1;
        end else begin
            by = refm[a];
            exp_ma[n] = 24'(b);
            case (op)
                3'd0: begin
                    lat = 1; exp_mr[n] = 1'b1;
                    exp_isld[n+1] = 1'b1; exp_ld[n+1] = win(b);
                end
                3'd1: begin
                    lat = 1; exp_mr[n] = 1'b1;
                    exp_isld[n+1] = 1'b1;
                    exp_ld[n+1] = {{16{by[7]}}, by};
                end
                3'd2: begin
                    lat = 1; exp_mr[n] = 1'b1;
                    exp_isld[n+1] = 1'b1; exp_ld[n+1] = {16'h0, by};
                end
                3'd3: begin
                    lat = 1; exp_mw[n] = 1'b1; exp_mwd[n] = data;
                    refm[a] = data[23:16];
                    refm[a+1] = data[15:8];
                    refm[a+2] = data[7:0];
                end
                default: begin
                    lat = 2; exp_mr[n] = 1'b1;
                    old = refm[a];
                    refm[a] = data[7:0];
                    mw = win(b);
                    if (abort) refm[a] = old;
                    exp_ma[n+1] = 24'(b);
                    exp_mwd[n+1] = mw;
                    exp_mw[n+1] = !abort;
                end
            endcase
        end
        for (int j = 0; j < lat; j++) exp_busy[n+j] = 1'b1;
        if (abort && lat == 2) begin
            exp_clr[n+2] = 1'b1;
            free_at = n + 2;
        end else begin
            exp_done[n+lat] = 1'b1;
            free_at = n + lat;
        end
        d = n + lat;
    endtask

    // Issue a request at the first idle cycle; junk Req while busy
    task automatic issue(input logic [2:0] op, input logic [23:0] addr,
                         input logic [23:0] data, input bit abort,
                         output int d);
        int n;
        while (cyc < free_at) begin
            Req = 1'($urandom_range(0, 1));
            Op = 3'($urandom_range(0, 7));
            Addr = 24'($urandom_range(0, 63));
            StoreData = 24'($urandom);
            step();
        end
        Req = 1'b1; Op = op; Addr = addr; StoreData = data;
        n = cyc + 1;
        model(op, addr, data, abort, n, d);
        step();
        Req = 1'b0;
        if (abort && op == 3'd4) begin
            step();
            Reset = 1'b1;
            step();
            Reset = 1'b0;
        end
    endtask

    task automatic wait_until(input int t);
        Req = 1'b0;
        while (cyc < t) step();
    endtask

    initial begin
        int d;
        logic [2:0] op;
        logic [23:0] a, sd;
        for (int i = 0; i < MEM; i++) begin
            mem[i] = 8'($urandom);
        end
        mem[16] = 8'hA1; mem[17] = 8'hB2; mem[18] = 8'hC3;
        mem[61] = 8'h01; mem[62] = 8'h02; mem[63] = 8'h83;
        for (int i = 0; i < MEM; i++) refm[i] = mem[i];

        step();
        step();
        Reset = 1'b0;
        chk1("rst_busy", Busy, 1'b0);
        chk("rst_loaddata", LoadData, 24'h0);

        issue(3'd0, 24'h10, 24'h0, 1'b0, d);
        wait_until(d);
        chk("lw_10", LoadData, 24'hA1B2C3);
        chk1("lw_done", Done, 1'b1);
        chk1("lw_fault", Fault, 1'b0);

        issue(3'd1, 24'h10, 24'h0, 1'b0, d);
        wait_until(d);
        chk("lb_10", LoadData, 24'hFFFFA1);
        issue(3'd2, 24'h10, 24'h0, 1'b0, d);
        wait_until(d);
        chk("lbu_10", LoadData, 24'h0000A1);
        issue(3'd1, 24'h3F, 24'h0, 1'b0, d);
        wait_until(d);
        chk("lb_3f", LoadData, 24'hFFFF83);

        issue(3'd4, 24'h11, 24'h00005A, 1'b0, d);
        wait_until(d);
        chk1("sb_done", Done, 1'b1);
        issue(3'd0, 24'h10, 24'h0, 1'b0, d);
        wait_until(d);
        chk("sb_then_lw", LoadData, 24'hA15AC3);

        issue(3'd3, 24'h3E, 24'h777777, 1'b0, d);
        wait_until(d);
        chk1("sw_oob_fault", Fault, 1'b1);
        chk1("sw_oob_done", Done, 1'b1);
        issue(3'd7, 24'h0, 24'h0, 1'b0, d);
        wait_until(d);
        chk1("op7_fault", Fault, 1'b1);

        issue(3'd3, 24'h20, 24'h123456, 1'b0, d);
        wait_until(d);
        issue(3'd0, 24'h20, 24'h0, 1'b0, d);
        wait_until(d);
        chk("b2b_lw", LoadData, 24'h123456);

        issue(3'd4, 24'h21, 24'h0000EE, 1'b1, d);
        chk1("abort_busy", Busy, 1'b0);
        chk1("abort_done", Done, 1'b0);
        issue(3'd0, 24'h20, 24'h0, 1'b0, d);
        wait_until(d);
        chk("abort_keep", LoadData, 24'h123456);

        for (int i = 0; i < 400; i++) begin
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0)
                a = 24'($urandom);
            else
                a = 24'($urandom_range(0, 66));
            sd = 24'($urandom);
            if (cyc >= free_at && $urandom_range(0, 3) == 0) begin
                Req = 1'b0;
                step();
            end
            issue(op, a, sd, 1'b0, d);
        end
        wait_until(free_at + 3);
        for (int i = 0; i < MEM; i++)
            chk("mem_byte", 24'(mem[i]), 24'(refm[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
